write_back: RTL and testbench

Write-back stage of the ARM_Calculator datapath. Holds the word-addressed data memory and selects the register-file result. It stores `WD` at address `ALUResult` when `MemWrite` is high, and reads the same address combinationally. It drives `Result` as either the memory read data or the ALU result, per `MemtoReg`. It sits after the ALU/execute stage; `Result` feeds the register-file write port.

---
 rtl/write_back_if.sv | 28 ++
 rtl/write_back.sv | 59 +++++
 tb/tb_write_back.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/write_back_if.sv
// Bus bundle between the execute stage and the write-back stage.
// The execute side (master) drives address/data/controls; the
// write-back side (slave) returns the selected register-file value.
interface write_back_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] ALUResult;
    logic [DATA_W-1:0] WD;
    logic              MemWrite;
    logic              MemtoReg;
    logic [DATA_W-1:0] Result;

    modport master (
        output ALUResult,
        output WD,
        output MemWrite,
        output MemtoReg,
        input  Result
    );

    modport slave (
        input  ALUResult,
        input  WD,
        input  MemWrite,
        input  MemtoReg,
        output Result
    );
endinterface

// File: rtl/write_back.sv
// Write-back stage: register-built word-addressed data memory with a
// combinational read port, plus the Result select between memory read
// data and the pass-through ALU result.
module write_back #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input logic         clk,
    input logic         reset,
    write_back_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    // Only the low bits index memory; upper bits wrap modulo depth.
    logic [ADDR_W-1:0] index;
    logic [DATA_W-1:0] read_array [DEPTH];
    logic [DATA_W-1:0] read_data;

    assign index = bus.ALUResult[ADDR_W-1:0];

    // One register per word so that reset can clear every word at once
    // and the read port can be a plain combinational mux.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            localparam logic [ADDR_W-1:0] WORD_IDX = ADDR_W'(gi);
            logic [DATA_W-1:0] word_q;
            logic [DATA_W-1:0] word_d;

            // Next value: take WD only when this word is the write target.
            always_comb begin
                word_d = word_q;
                if (bus.MemWrite && (index == WORD_IDX)) begin
                    word_d = bus.WD;
                end
            end

            // Reset clears the word and wins over any write in that cycle.
            always_ff @(posedge clk) begin
                if (reset) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end

            assign read_array[gi] = word_q;
        end
    endgenerate

    // Asynchronous read; no bypass of the write data in the same cycle.
    always_comb begin
        read_data = read_array[index];
    end

    // Select the register-file write-back value.
    always_comb begin
        bus.Result = bus.MemtoReg ? read_data : bus.ALUResult;
    end
endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: directed vectors with literal
// expectations plus a per-cycle comparison against a memory model.
module tb_write_back;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic started;

    write_back_if #(.DATA_W(DATA_W)) bus ();

    write_back #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference memory: a plain array indexed by address modulo depth.
    logic [DATA_W-1:0] model_mem [DEPTH];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        end else if (bus.MemWrite) begin
            model_mem[bus.ALUResult % DEPTH] = bus.WD;
        end
    end

    // Per-cycle comparison on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [DATA_W-1:0] exp_v;
        if (started) begin
            exp_v = bus.MemtoReg ? model_mem[bus.ALUResult % DEPTH] : bus.ALUResult;
            checks++;
            if (bus.Result !== exp_v) begin
                errors++;
                $display("FAIL model_cycle t=%0t addr=%0d m2r=%0b got=%h exp=%h",
                         $time, bus.ALUResult, bus.MemtoReg, bus.Result, exp_v);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_lit(input string name, input logic [DATA_W-1:0] exp_v);
        checks++;
        if (bus.Result !== exp_v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, bus.Result, exp_v);
        end else begin
            $display("ok   %s addr=%0d m2r=%0b result=%h", name, bus.ALUResult,
                     bus.MemtoReg, bus.Result);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        started = 1'b0;
        reset   = 1'b1;
        bus.ALUResult = '0;
        bus.WD        = '0;
        bus.MemWrite  = 1'b0;
        bus.MemtoReg  = 1'b0;
        repeat (2) step();
        started = 1'b1;
        reset   = 1'b0;

        // 1: read after reset, no write
        bus.MemtoReg = 1'b1; bus.ALUResult = 12; bus.WD = 989; bus.MemWrite = 1'b0;
        #1 check_lit("t1_reset_read", 32'd0);
        step();
        check_lit("t1_no_write", 32'd0);

        // 2: distinct words 12 and 13
        bus.ALUResult = 12; bus.WD = 0; bus.MemWrite = 1'b1;
        step();
        bus.ALUResult = 13; bus.WD = 4554;
        step();
        bus.MemWrite = 1'b0;
        #1 check_lit("t2_addr13", 32'd4554);
        bus.ALUResult = 12;
        #1 check_lit("t2_addr12", 32'd0);

        // 3: mux bypass while writing
        bus.ALUResult = 12; bus.WD = 4554; bus.MemWrite = 1'b1; bus.MemtoReg = 1'b0;
        #1 check_lit("t3_bypass", 32'd12);
        step();
        bus.MemWrite = 1'b0; bus.MemtoReg = 1'b1;
        #1 check_lit("t3_written", 32'd4554);

        // 4: wrap-around, upper bits ignored for indexing only
        bus.ALUResult = 76; bus.WD = 32'hDEADBEEF; bus.MemWrite = 1'b1;
        step();
        bus.MemWrite = 1'b0; bus.ALUResult = 12;
        #1 check_lit("t4_wrap", 32'hDEADBEEF);
        bus.MemtoReg = 1'b0; bus.ALUResult = 32'hFFFF_FF4C;
        #1 check_lit("t4_full_width", 32'hFFFF_FF4C);
        bus.MemtoReg = 1'b1;
        #1 check_lit("t4_hi_alias", 32'hDEADBEEF);

        // 5: reset priority over write; all prior writes discarded
        reset = 1'b1; bus.MemWrite = 1'b1; bus.WD = 77; bus.ALUResult = 5;
        step();
        reset = 1'b0; bus.MemWrite = 1'b0;
        #1 check_lit("t5_addr5", 32'd0);
        bus.ALUResult = 12;
        #1 check_lit("t5_addr12", 32'd0);
        bus.ALUResult = 13;
        #1 check_lit("t5_addr13", 32'd0);

        // 6: read-during-write, no write-through
        bus.ALUResult = 20; bus.WD = 111; bus.MemWrite = 1'b1;
        step();
        bus.WD = 222;
        #1 check_lit("t6_before", 32'd111);
        step();
        bus.MemWrite = 1'b0;
        #1 check_lit("t6_after", 32'd222);

        // back-to-back writes to one address keep the last value
        bus.ALUResult = 30; bus.MemWrite = 1'b1;
        bus.WD = 1; step();
        bus.WD = 2; step();
        bus.WD = 3; step();
        bus.MemWrite = 1'b0;
        #1 check_lit("b2b_last", 32'd3);

        // mixed traffic, checked by the per-cycle model compare
        for (int n = 0; n < 300; n++) begin
            reset         = ($urandom_range(0, 49) == 0);
            bus.ALUResult = $urandom();
            bus.WD        = $urandom();
            bus.MemWrite  = $urandom_range(0, 1) == 1;
            bus.MemtoReg  = $urandom_range(0, 3) != 0;
            step();
        end
        reset = 1'b0;
        bus.MemWrite = 1'b0;
        step();

        started = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
